// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one AND/OR/ADD/SUB ALU between two
// requesters, with a registered, tagged response and a wrapping count of
// completed operations.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic             gnt_id;
  logic             accept;
  logic             lat_id;
  logic [3:0]       lat_op;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;
  logic             alu_zero;

  // Arbitration, request readies and next-state selection.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nx   = state;
    // On contention the requester that did not win last time is chosen.
    gnt_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    case (state)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          state_nx   = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept    = req0_ready | req1_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Shared ALU, driven only from the latched request fields.
  always_comb begin
    alu_result = '0;
    alu_err    = 1'b0;
    case (lat_op)
      4'b0000:          alu_result = lat_a & lat_b;
      4'b0001:          alu_result = lat_a | lat_b;
      4'b0010:          alu_result = lat_a + lat_b;
      4'b0110, 4'b0111: alu_result = lat_a - lat_b;
      default: begin
        alu_result = '0;
        alu_err    = 1'b1;
      end
    endcase
    alu_zero = ~alu_err && (alu_result == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Request latch, response registers, grant history and completion counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_op     <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      if (accept) begin
        lat_id <= gnt_id;
        lat_op <= gnt_id ? req1_op : req0_op;
        lat_a  <= gnt_id ? req1_a  : req0_a;
        lat_b  <= gnt_id ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        rsp_id     <= lat_id;
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= alu_err;
        last_grant <= lat_id;
      end
      if ((state == RESP) && rsp_ready) begin
        ops_done <= ops_done + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, ALU results, response
// stalling, mid-operation reset and counter wrap (narrow-counter instance).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [31:0] rsp_result;
  logic [15:0] ops_done;

  logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
  logic        s_rsp_zero, s_rsp_err, s_busy;
  logic [31:0] s_rsp_result;
  logic [1:0]  s_ops_done;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy), .ops_done(ops_done)
  );

  alu_arbiter #(.WIDTH(32), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
    .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero), .rsp_err(s_rsp_err),
    .busy(s_busy), .ops_done(s_ops_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-requester transaction with rsp_ready held high; starts in IDLE.
  task automatic do_op(input string tag, input logic id, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z, input logic e);
    rsp_ready = 1'b1;
    if (!id) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    chk({tag, "_rdy0"}, {31'd0, req0_ready}, {31'd0, ~id});
    chk({tag, "_rdy1"}, {31'd0, req1_ready}, {31'd0, id});
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_exec_vld"}, {31'd0, rsp_valid}, 32'd0);
    step();
    chk({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    chk({tag, "_res"}, rsp_result, r);
    chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, z});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e});
    step();
    exp_ops++;
    chk({tag, "_ops"}, {16'd0, ops_done}, exp_ops & 32'hFFFF);
    chk({tag, "_ops_small"}, {30'd0, s_ops_done}, exp_ops % 4);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    step();
    chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    chk("rst_vld", {31'd0, rsp_valid}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_res", rsp_result, 32'd0);
    chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ops", {16'd0, ops_done}, 32'd0);
    step();

    do_op("add", 1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    do_op("sub_eq", 1'b1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    do_op("sub_wrap", 1'b1, 4'b0111, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Contention: last grant was 1, so order is 0,1,0,1.
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1;  req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 4'b0110; req1_a = 32'd10; req1_b = 32'd3;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = logic'(i % 2);
      #1;
      chk("rr_rdy0", {31'd0, req0_ready}, {31'd0, ~g});
      chk("rr_rdy1", {31'd0, req1_ready}, {31'd0, g});
      step();
      chk("rr_exec_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
      chk("rr_resp_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rr_id", {31'd0, rsp_id}, {31'd0, g});
      chk("rr_res", rsp_result, g ? 32'd7 : 32'd3);
      step();
      exp_ops++;
      chk("rr_ops", {16'd0, ops_done}, exp_ops & 32'hFFFF);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Response stall: AND with rsp_ready low for 10 RESP cycles.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'hF0F0; req0_b = 32'h0FF0;
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'd1; req1_b = 32'd2;
    for (int i = 0; i < 10; i++) begin
      chk("stall_vld", {31'd0, rsp_valid}, 32'd1);
      chk("stall_res", rsp_result, 32'h0000_00F0);
      chk("stall_id", {31'd0, rsp_id}, 32'd0);
      chk("stall_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_ops", {16'd0, ops_done}, exp_ops & 32'hFFFF);
      step();
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    exp_ops++;
    chk("stall_done_busy", {31'd0, busy}, 32'd0);
    chk("stall_done_ops", {16'd0, ops_done}, exp_ops & 32'hFFFF);

    do_op("illegal", 1'b0, 4'b1010, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);
    do_op("or", 1'b0, 4'b0001, 32'hF000, 32'h000F, 32'hF00F, 1'b0, 1'b0);

    // Reset during EXEC; last grant was 0, so without reset req1 would win next.
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd1; req1_b = 32'd1;
    step();
    req1_valid = 1'b0;
    chk("mid_exec_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_ops = 0;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_vld", {31'd0, rsp_valid}, 32'd0);
    chk("mid_ops", {16'd0, ops_done}, 32'd0);
    chk("mid_ops_small", {30'd0, s_ops_done}, 32'd0);
    step();
    step();
    chk("mid_vld_late", {31'd0, rsp_valid}, 32'd0);
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd2; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd3; req1_b = 32'd3;
    #1;
    chk("mid_rdy0", {31'd0, req0_ready}, 32'd1);
    chk("mid_rdy1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("mid_res", rsp_result, 32'd4);
    step();
    exp_ops++;
    chk("mid_ops1", {16'd0, ops_done}, 32'd1);

    // Three more completions: narrow counter goes 3 -> 0 on the last.
    do_op("wrap_a", 1'b1, 4'b0000, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0);
    do_op("wrap_b", 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    do_op("wrap_c", 1'b1, 4'b0001, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("wrap_small_zero", {30'd0, s_ops_done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU (AND/OR/ADD/SUB) between two requesters, such as the execute stage and an address-generation or debug unit. Arbitration is round-robin. Each request is accepted with a valid/ready handshake, the operands are latched, the ALU result and zero flag are computed into a register, and a tagged response is returned over a valid/ready channel. A saturating-free, wrapping operation counter supports performance monitoring.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, width of completed-operation counter
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid / req1_valid  input  1  requester 0/1 has a request
- req0_ready / req1_ready  output  1  request accepted this cycle
- req0_op / req1_op  input  4  operation code
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that owns the response
- rsp_result  output  WIDTH  ALU result
- rsp_zero  output  1  result equals zero (legal ops only)
- rsp_err  output  1  op code was illegal
- busy  output  1  state is not IDLE
- ops_done  output  CNT_W  count of completed response handshakes

## Operation
- Op encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (mod 2^WIDTH, carry discarded)
  - 0110 SUB (a−b, mod 2^WIDTH)
  - 0111 SUB (identical to 0110)
  - Any other code is illegal: result 0, rsp_err=1, rsp_zero=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no req_valid is high, stay in IDLE.
  - If exactly one req_valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - The granted reqN_ready is asserted combinationally in the same cycle; the other ready stays 0.
  - On the edge: latch id, op, a and b; go to EXEC.
- EXEC:
  - Drive the ALU from the latched fields.
  - Register result, zero and err into the response registers.
  - Set last_grant to the latched id; go to RESP.
- RESP:
  - rsp_valid=1. rsp_* hold stable until rsp_ready=1.
  - On the handshake: increment ops_done (wraps at 2^CNT_W−1 → 0); go to IDLE.
- Both req_ready outputs are 0 in EXEC and RESP. New requests wait; they are never dropped or queued internally.
- Requesters must hold valid, op and operands stable until their ready is asserted.
- reqN_ready may depend combinationally on reqN_valid. No ready depends on rsp_ready.

## Timing
- Reset values:
  - state=IDLE, last_grant=1, so requester 0 wins the first contention.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - busy=0, ops_done=0. Both readies are 0 while rst_n=0.
- Latency: accept at cycle T (IDLE). Result registered at the end of T+1 (EXEC). rsp_valid=1 from cycle T+2.
- Minimum spacing: 3 cycles from one acceptance to the next, when rsp_ready is held at 1.
- rsp_ready held low: stay in RESP indefinitely; outputs do not change.
- Simultaneous requests with valid held high: grants alternate 0,1,0,1…
- One requester continuously valid, other idle: it is granted every opportunity.
- Reset asserted mid-operation (EXEC or RESP): the in-flight transaction is discarded with no response. Next cycle is IDLE with reset values, including last_grant=1.
- rsp_zero is taken from the registered result of the same operation. It is never combinational from the current inputs.

## Test plan
- Reset, then req0 ADD a=5 b=7 with rsp_ready=1 → req0_ready at T, rsp_valid at T+2 with id=0, result=12, zero=0, err=0; ops_done=1 after the handshake.
- req1 SUB a=9 b=9, then SUB(0111) a=0 b=1 → first: result=0, zero=1. Second: result=0xFFFFFFFF, zero=0.
- Both valid continuously, 4 operations → grant order 0,1,0,1; rsp_id matches; each requester's ready is high only in its grant cycle.
- rsp_ready held low for 10 cycles in RESP → rsp_* stable, both readies 0, busy=1; the handshake on cycle 11 returns to IDLE.
- Op 1010 a=3 b=4 → result=0, err=1, zero=0. AND 0xF0F0 & 0x0FF0 → 0x00F0. OR 0xF000 | 0x000F → 0xF00F.
- rst_n low during EXEC → no rsp_valid afterwards, ops_done=0, next contention grants requester 0; preload ops_done=0xFFFF (CNT_W=16) and one completion → 0x0000.
